vga_timing_generator: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock. It is the stage directly upstream of the pixel drawer and feeds it the `row`/`col` coordinates. It is also the final output register: it captures the drawer's combinational RGB, blanks it outside the visible area, and drives the VGA connector. Sync outputs are delayed so that they stay aligned with the captured RGB.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_pixel_divider.sv | 38 +++
 rtl/vga_timing_generator.sv | 143 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator: default 640x480@60 Hz
// timing constants, the derived line/frame totals, the 4-bit-per-channel
// colour struct and a small range helper used for sync decoding.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 16;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    // Half-open interval test: lo <= x < hi
    function automatic logic in_range(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_pixel_divider.sv
// -----------------------------------------------------------------------------
// vga_pixel_divider
// Divides the system clock down to the pixel rate. The counter wraps over
// 0..CLK_DIV-1 and `advance` is high on the last clock of each pixel period.
// It resets to CLK_DIV-1 so the very first edge after reset is an advance edge.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   advance  out  high in the clock whose rising edge moves to the next pixel
// -----------------------------------------------------------------------------
module vga_pixel_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic advance
);

    // With CLK_DIV=1 the counter degenerates to a constant 0 and every edge advances.
    localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    assign advance = (div == DIV_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= DIV_MAX;
        end else if (advance) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
// VGA raster timing plus the final colour/sync output register. The position
// registers (col/row/video_on) describe the pixel the drawer should be
// colouring now; one pixel period later that colour is captured, blanked and
// driven out together with the syncs decoded from the same position.
//
// Optional feature: define VGA_FRAME_COUNTER_EN to build the 16-bit frame
// counter; otherwise frame_count is tied to 0.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   red_in/green_in/blue_in      drawer colour for the current row/col
//   col, row                     visible coordinates (0 during blanking)
//   video_on                     current pixel is visible
//   pixel_tick                   first clock of each pixel period
//   frame_start                  first clock of pixel (0,0)
//   frame_count                  frames since reset (optional)
//   vga_hs, vga_vs               active-low syncs, aligned with colour
//   vga_r/g/b                    blanked, registered colour
// -----------------------------------------------------------------------------
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         red_in,
    input  logic [3:0]         green_in,
    input  logic [3:0]         blue_in,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               video_on,
    output logic               pixel_tick,
    output logic               frame_start,
    output logic [15:0]        frame_count,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b
);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               advance;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic [COORD_W-1:0] h_nxt;
    logic [COORD_W-1:0] v_nxt;
    logic               vis_nxt;
    logic               at_origin;
    rgb4_t              pix_in;
    rgb4_t              pix_out;

    vga_pixel_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance)
    );

    assign pix_in = '{r: red_in, g: green_in, b: blue_in};

    always_comb begin
        h_nxt = (h == H_LAST) ? '0 : h + 1'b1;
        v_nxt = v;
        if (h == H_LAST) begin
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
        vis_nxt   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        at_origin = (h_nxt == '0) && (v_nxt == '0);
    end

    // Position registers take the incoming pixel; the output stage takes the
    // outgoing one (old h/v/video_on), which is what gives the one-pixel lag
    // between row/col and the connector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h           <= H_LAST;
            v           <= V_LAST;
            col         <= '0;
            row         <= '0;
            video_on    <= 1'b0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
            pix_out     <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
        end else begin
            pixel_tick  <= advance;
            frame_start <= advance && at_origin;
            if (advance) begin
                h        <= h_nxt;
                v        <= v_nxt;
                video_on <= vis_nxt;
                col      <= vis_nxt ? h_nxt : '0;
                row      <= vis_nxt ? v_nxt : '0;
                pix_out  <= video_on ? pix_in : '0;
                vga_hs   <= !in_range(h, HS_START, HS_END);
                vga_vs   <= !in_range(v, VS_START, VS_END);
            end
        end
    end

    assign vga_r = pix_out.r;
    assign vga_g = pix_out.g;
    assign vga_b = pix_out.b;

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_generator
// Drives a shrunken raster (15x10 pixels, CLK_DIV=2) so several frames fit in
// a short run. A pixel-index model derives every output from the number of
// clock edges since reset release; literal expectations pin line/sync/frame
// timing and the asynchronous mid-line reset.
// -----------------------------------------------------------------------------
module tb_vga_timing_generator;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam int DIV = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  red_in = '0, green_in = '0, blue_in = '0;
    logic [15:0] col, row, frame_count;
    logic        video_on, pixel_tick, frame_start, vga_hs, vga_vs;
    logic [3:0]  vga_r, vga_g, vga_b;

    vga_timing_generator #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .CLK_DIV   (DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .col         (col),
        .row         (row),
        .video_on    (video_on),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    int edges = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int fc_m = 0;
    int first_hs = 0, hs_run = 0, hs_len = 0;
    int vs_run = 0, vs_len = 0;
    int first_fs = 0, last_fs = 0, fs_period = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [11:0] cf(input int h, input int v);
        logic [3:0] r, g, b;
        r = 4'(h + v);
        g = ~4'(h);
        b = 4'(v * 3);
        return {r, g, b};
    endfunction

    // Rising edges seen since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges = 0;
        else edges++;
    end

    always @(negedge clk) begin
        int p, q, h, v, hq, vq, exp_col, exp_row, exp_fc;
        logic tick, vis, visq, fs, hs_e, vs_e;
        logic [11:0] rgb_e;
        if (edges == 0) begin
            h = 0; v = 0; tick = 1'b0; vis = 1'b0; fs = 1'b0;
            hs_e = 1'b1; vs_e = 1'b1; rgb_e = '0;
            fc_m = 0;
        end else begin
            p    = (edges - 1) / DIV;
            tick = ((edges - 1) % DIV) == 0;
            h    = p % HT;
            v    = (p / HT) % VT;
            vis  = (h < HV) && (v < VV);
            fs   = tick && (h == 0) && (v == 0);
            q    = p - 1;
            if (q < 0) begin
                hq = HT - 1; vq = VT - 1; visq = 1'b0;
            end else begin
                hq = q % HT; vq = (q / HT) % VT; visq = (hq < HV) && (vq < VV);
            end
            hs_e  = !((hq >= HV + HF) && (hq < HV + HF + HS));
            vs_e  = !((vq >= VV + VF) && (vq < VV + VF + VS));
            rgb_e = visq ? cf(hq, vq) : 12'h000;
        end
        exp_col = vis ? h : 0;
        exp_row = vis ? v : 0;
`ifdef VGA_FRAME_COUNTER_EN
        exp_fc = fc_m;
`else
        exp_fc = 0;
`endif
        chk("col", int'(col), exp_col);
        chk("row", int'(row), exp_row);
        chk("video_on", int'(video_on), int'(vis));
        chk("pixel_tick", int'(pixel_tick), int'(tick));
        chk("frame_start", int'(frame_start), int'(fs));
        chk("frame_count", int'(frame_count), exp_fc);
        chk("vga_hs", int'(vga_hs), int'(hs_e));
        chk("vga_vs", int'(vga_vs), int'(vs_e));
        chk("vga_rgb", int'({vga_r, vga_g, vga_b}), int'(rgb_e));
        if (fs) fc_m++;

        if (edges == 0) begin
            hs_run = 0; vs_run = 0; last_fs = 0;
        end else begin
            if (!vga_hs) begin
                hs_run++;
                if (first_hs == 0) first_hs = edges;
            end else begin
                if (hs_run > 0) hs_len = hs_run;
                hs_run = 0;
            end
            if (!vga_vs) vs_run++;
            else begin
                if (vs_run > 0) vs_len = vs_run;
                vs_run = 0;
            end
            if (frame_start) begin
                if (first_fs == 0) first_fs = edges;
                if (last_fs > 0) fs_period = edges - last_fs;
                last_fs = edges;
            end
        end

        {red_in, green_in, blue_in} = (edges == 0) ? 12'h000 : cf(h, v);
    end

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        repeat (700) @(posedge clk);
        #2;
        chk("first_fs_edge", first_fs, 1);
        chk("first_hs_low_edge", first_hs, 23);
        chk("hs_low_cycles", hs_len, HS * DIV);
        chk("vs_low_cycles", vs_len, 60);
        chk("frame_period", fs_period, 300);

        // Run to pixel (5,2) and pull reset in the middle of that pixel
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!((((edges - 1) / DIV) % HT == 5) && ((((edges - 1) / DIV) / HT) % VT == 2)) && n < 400);
        chk("reach_midline", int'(n < 400), 1);
        chk("col_before_reset", int'(col), 5);
        chk("row_before_reset", int'(row), 2);
        chk("tick_before_reset", int'(pixel_tick), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_video_on", int'(video_on), 0);
        chk("rst_pixel_tick", int'(pixel_tick), 0);
        chk("rst_vga_hs", int'(vga_hs), 1);
        chk("rst_vga_vs", int'(vga_vs), 1);
        chk("rst_frame_count", int'(frame_count), 0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk("restart_frame_start", int'(frame_start), 1);
        chk("restart_pixel_tick", int'(pixel_tick), 1);
        chk("restart_video_on", int'(video_on), 1);
        chk("restart_col", int'(col), 0);
        chk("restart_row", int'(row), 0);

        repeat (650) @(posedge clk);
        #2;
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame_count_3_frames", int'(frame_count), 3);
`else
        chk("frame_count_tied", int'(frame_count), 0);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
